reg_dump_reader: RTL
====================

// Module: reg_dump_reader
// PURPOSE
//  Debug reader for the Register_File: on request, walks register indices via a dedicated
//  read-address port, captures each 32-bit value and streams it out over a valid/ready
//  handshake (to UART/debug bridge). Replaces ILA probing of register contents.
//  Sits beside the datapath; reads only, never drives A3/WD3/WE3.
// PARAMETERS
//  NUM_REGS   32  registers scanned, indices 0..NUM_REGS-1 (2..32)
//  ADDR_W     5   register index width
//  DATA_W     32  register data width
//  SKIP_ZERO  0   1: scan starts at index 1 ($0 is never emitted)
// PORTS
//  CLK        in   1       clock; all state changes on posedge
//  RESET      in   1       asynchronous, active-low reset
//  START      in   1       begin a dump; sampled only in IDLE
//  ABORT      in   1       synchronous cancel; wins over all other events
//  RA         out  ADDR_W  read address to Register_File extra read port
//  RD         in   DATA_W  combinational read data for RA
//  OUT_DATA   out  DATA_W  streamed word
//  OUT_IDX    out  ADDR_W  register index of OUT_DATA
//  OUT_LAST   out  1       marks final word of the dump
//  OUT_VALID  out  1       word valid
//  OUT_READY  in   1       sink accepts when OUT_VALID && OUT_READY at posedge
//  BUSY       out  1       high in any state except IDLE
//  DONE       out  1       one-cycle pulse after final word accepted
// BEHAVIOUR
//  - Reset (RESET=0): state IDLE; RA, OUT_DATA, OUT_IDX=0; OUT_LAST, OUT_VALID, BUSY, DONE=0.
//  - FSM: IDLE -> LOAD -> SEND -> (LOAD | CSUM | IDLE).
//    IDLE: START=1 -> idx<=first (0, or 1 if SKIP_ZERO), LOAD. DONE=0.
//    LOAD: RA=idx all cycle; at posedge OUT_DATA<=RD, OUT_IDX<=idx, OUT_VALID<=1, -> SEND.
//    SEND: hold OUT_DATA/OUT_IDX/OUT_LAST stable while OUT_VALID && !OUT_READY.
//      On accept: idx==NUM_REGS-1 -> CSUM if enabled, else OUT_VALID<=0, DONE<=1, IDLE;
//      else idx<=idx+1, OUT_VALID<=0, -> LOAD.
//  - RF writes on negedge, so RD sampled at posedge is settled; one word per 2 cycles max.
//  - Dump not atomic: a write to register k before its LOAD is visible; after, it is not.
//  - OUT_LAST=1 with the final word only (register NUM_REGS-1, or checksum word).
//  - ABORT=1 in any state: next posedge -> IDLE, OUT_VALID=0, DONE not pulsed, no partial
//    word completion; the only permitted VALID drop without handshake.
//  - START while BUSY ignored. START and ABORT same cycle in IDLE: stay IDLE.
//  - idx counter never wraps: terminal compare stops it at NUM_REGS-1.
//  - Mid-operation RESET: immediate asynchronous return to reset values.
// CONFIGURATION
//  `REG_DUMP_CHECKSUM_EN defined: running XOR of all emitted words; after last register,
//    CSUM state emits XOR as extra word, OUT_IDX=0, OUT_LAST=1; DONE after its accept.
//    Accumulator cleared on START and ABORT.
//  Undefined: no CSUM state, no accumulator; OUT_LAST on register NUM_REGS-1.
// STRUCTURE
//  - Shared header mcu_defs.vh: state encodings (IDLE/LOAD/SEND/CSUM), RF_ADDR_W=5,
//    RF_DATA_W=32, RF_NUM_REGS=32.
//  - One sub-module, dump_checksum (XOR accumulator, clear/enable), instantiated only
//    under `REG_DUMP_CHECKSUM_EN. FSM and index counter live in top.
//  - Register_File gains third read port A4/RD4 wired to RA/RD.
// TESTING
//  1 RF preloaded reg[i]=0x1000_0000+i, OUT_READY=1, pulse START -> 32 words, IDX 0..31,
//    data 0x1000_0000..0x1000_001F, OUT_LAST on 31, DONE one cycle later, 64 cycles total.
//  2 Random OUT_READY backpressure (~50%) -> OUT_DATA/IDX stable while stalled; no loss/dup.
//  3 ABORT after word idx=10 accepted -> IDLE next cycle, VALID=0, no DONE; new START
//    restarts at idx 0.
//  4 SKIP_ZERO=1 -> first word OUT_IDX=1, 31 words total.
//  5 `REG_DUMP_CHECKSUM_EN, pattern of test 1 -> 33rd word=XOR=0x0000_0000 (32 words, upper
//    bits cancel, low XOR of 0..31=0), OUT_IDX=0, OUT_LAST=1; reg[5]=0xDEADBEEF -> checksum
//    changes to 0xDEADBEEF^0x1000_0005.
//  6 RESET low during SEND -> all outputs 0 immediately; START then ignored while RESET=0.

Source files
------------

// File: rtl/reg_dump_reader_pkg.sv
// Shared constants and FSM encoding for the register-file dump reader.
package reg_dump_reader_pkg;

    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_CSUM = 2'd3
    } dump_state_e;

endpackage

// File: rtl/reg_dump_reader_checksum.sv
// XOR accumulator over emitted dump words; only exists when REG_DUMP_CHECKSUM_EN is defined.
`ifdef REG_DUMP_CHECKSUM_EN
module dump_checksum #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] acc
);

    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;

    // Clear beats accumulate so a START/ABORT edge always begins from zero.
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q ^ din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule
`endif

// File: rtl/reg_dump_reader.sv
// Debug reader that walks the register file through a spare read port and streams each word
// out over valid/ready. Optional trailing XOR checksum word under REG_DUMP_CHECKSUM_EN.
module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter int NUM_REGS  = RF_NUM_REGS,
    parameter int ADDR_W    = RF_ADDR_W,
    parameter int DATA_W    = RF_DATA_W,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic              ABORT,
    output logic [ADDR_W-1:0] RA,
    input  logic [DATA_W-1:0] RD,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [ADDR_W-1:0] OUT_IDX,
    output logic              OUT_LAST,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [ADDR_W-1:0] FIRST_IDX = SKIP_ZERO ? ADDR_W'(1) : '0;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] oidx_q, oidx_d;
    logic              last_q, last_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;

`ifdef REG_DUMP_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;

    logic [DATA_W-1:0] csum_acc;
    logic              csum_clr;
    logic              csum_en;

    assign csum_clr = ABORT || (state_q == ST_IDLE && START);
    assign csum_en  = (state_q == ST_SEND) && valid_q && OUT_READY && !ABORT;

    dump_checksum #(
        .DATA_W(DATA_W)
    ) u_csum (
        .clk  (CLK),
        .rst_n(RESET),
        .clr  (csum_clr),
        .en   (csum_en),
        .din  (data_q),
        .acc  (csum_acc)
    );
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        oidx_d  = oidx_q;
        last_d  = last_q;
        valid_d = valid_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    idx_d   = FIRST_IDX;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                data_d  = RD;
                oidx_d  = idx_q;
                valid_d = 1'b1;
                last_d  = (idx_q == LAST_IDX) && !CSUM_EN;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (OUT_READY) begin
                    if (idx_q == LAST_IDX) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        // Fold the word being accepted now; valid stays high into CSUM.
                        data_d  = csum_acc ^ data_q;
                        oidx_d  = '0;
                        last_d  = 1'b1;
                        state_d = ST_CSUM;
`else
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
`endif
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        valid_d = 1'b0;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_CSUM: begin
                if (OUT_READY) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort drops the word mid-handshake and suppresses any completion.
        if (ABORT) begin
            state_d = ST_IDLE;
            idx_d   = idx_q;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            oidx_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            oidx_q  <= oidx_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign RA        = idx_q;
    assign OUT_DATA  = data_q;
    assign OUT_IDX   = oidx_q;
    assign OUT_LAST  = last_q;
    assign OUT_VALID = valid_q;
    assign BUSY      = (state_q != ST_IDLE);
    assign DONE      = done_q;

endmodule
